csr_trap_seq: RTL and testbench

//  Initiator side of the machine-mode CSR port: sequences the CSR reads and writes
//  for trap entry (ecall/interrupt) and trap return (mret), one CSR access per cycle.

---
 rtl/csr_trap_seq.sv | 155 +++++++++++++++
 tb/tb_csr_trap_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_seq.sv
// Machine-mode CSR trap sequencer: steps trap entry and mret through the CSR file,
// one access per cycle, stalls upstream while busy, then pulses one PC redirect.
module csr_trap_seq #(
  parameter int XLEN        = 64,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            trap_req_i,
  input  logic            mret_req_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_cause_i,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            csr_wen_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            stall_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [3:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    R_MSTAT,
    W_MSTAT,
    R_MTVEC,
    REDIR,
    M_RSTAT,
    M_WSTAT,
    M_RMEPC
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] cause_q;
  logic [11:0]     csr_addr_q;
  logic [XLEN-1:0] csr_wdata_q;
  logic            csr_wen_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic [XLEN-1:0] ms_trap_d;
  logic [XLEN-1:0] ms_mret_d;
  logic [XLEN-1:0] trap_target_d;
  logic [XLEN-1:0] mret_target_d;
  logic [XLEN-1:0] tv_base;

  // Next-cycle values are derived straight from csr_rdata_i so that every output
  // can be registered on entry to the state that drives it.
  always_comb begin
    ms_trap_d         = csr_rdata_i;
    ms_trap_d[7]      = csr_rdata_i[3];
    ms_trap_d[3]      = 1'b0;
    ms_trap_d[12:11]  = 2'b11;

    ms_mret_d         = csr_rdata_i;
    ms_mret_d[3]      = csr_rdata_i[7];
    ms_mret_d[7]      = 1'b1;
    ms_mret_d[12:11]  = 2'b11;

    tv_base       = {csr_rdata_i[XLEN-1:2], 2'b00};
    trap_target_d = tv_base;
    if (VECTORED_EN && (csr_rdata_i[1:0] == 2'b01) && cause_q[XLEN-1])
      trap_target_d = tv_base + {cause_q[XLEN-3:0], 2'b00};

    mret_target_d = {csr_rdata_i[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q          <= IDLE;
      cause_q          <= '0;
      csr_addr_q       <= '0;
      csr_wdata_q      <= '0;
      csr_wen_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      csr_addr_q       <= '0;
      csr_wdata_q      <= '0;
      csr_wen_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trap_req_i) begin
            state_q     <= W_MEPC;
            cause_q     <= trap_cause_i;
            csr_addr_q  <= ADDR_MEPC;
            csr_wdata_q <= trap_pc_i;
            csr_wen_q   <= 1'b1;
          end else if (mret_req_i) begin
            state_q    <= M_RSTAT;
            csr_addr_q <= ADDR_MSTATUS;
          end
        end
        W_MEPC: begin
          state_q     <= W_MCAUSE;
          csr_addr_q  <= ADDR_MCAUSE;
          csr_wdata_q <= cause_q;
          csr_wen_q   <= 1'b1;
        end
        W_MCAUSE: begin
          state_q    <= R_MSTAT;
          csr_addr_q <= ADDR_MSTATUS;
        end
        R_MSTAT: begin
          state_q     <= W_MSTAT;
          csr_addr_q  <= ADDR_MSTATUS;
          csr_wdata_q <= ms_trap_d;
          csr_wen_q   <= 1'b1;
        end
        W_MSTAT: begin
          state_q    <= R_MTVEC;
          csr_addr_q <= ADDR_MTVEC;
        end
        R_MTVEC: begin
          state_q          <= REDIR;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= trap_target_d;
        end
        M_RSTAT: begin
          state_q     <= M_WSTAT;
          csr_addr_q  <= ADDR_MSTATUS;
          csr_wdata_q <= ms_mret_d;
          csr_wen_q   <= 1'b1;
        end
        M_WSTAT: begin
          state_q    <= M_RMEPC;
          csr_addr_q <= ADDR_MEPC;
        end
        M_RMEPC: begin
          state_q          <= REDIR;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= mret_target_d;
        end
        REDIR:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o          = (state_q != IDLE) || trap_req_i || mret_req_i;
  assign csr_addr_o       = csr_addr_q;
  assign csr_wdata_o      = csr_wdata_q;
  assign csr_wen_o        = csr_wen_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_seq.sv
// Bench for csr_trap_seq: vectored and direct-mode instances side by side, each
// attached to its own CSR file model, checked against a spec-level expectation.
`timescale 1ns/1ps
module tb_csr_trap_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        trap_req, mret_req;
  logic [63:0] trap_pc, trap_cause;

  logic [11:0] addr_v, addr_d;
  logic [63:0] wdata_v, wdata_d, rdata_v, rdata_d, rpc_v, rpc_d;
  logic        wen_v, wen_d, stall_v, stall_d, rv_v, rv_d;

  logic        load_en;
  logic [63:0] load_ms, load_tv, load_ep;
  logic [63:0] mem_v [4];
  logic [63:0] mem_d [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  csr_trap_seq #(.XLEN(64), .VECTORED_EN(1'b1)) dut_v (
    .clock_i(clock), .reset_i(reset), .trap_req_i(trap_req), .mret_req_i(mret_req),
    .trap_pc_i(trap_pc), .trap_cause_i(trap_cause), .csr_addr_o(addr_v),
    .csr_wdata_o(wdata_v), .csr_wen_o(wen_v), .csr_rdata_i(rdata_v), .stall_o(stall_v),
    .redirect_valid_o(rv_v), .redirect_pc_o(rpc_v));

  csr_trap_seq #(.XLEN(64), .VECTORED_EN(1'b0)) dut_d (
    .clock_i(clock), .reset_i(reset), .trap_req_i(trap_req), .mret_req_i(mret_req),
    .trap_pc_i(trap_pc), .trap_cause_i(trap_cause), .csr_addr_o(addr_d),
    .csr_wdata_o(wdata_d), .csr_wen_o(wen_d), .csr_rdata_i(rdata_d), .stall_o(stall_d),
    .redirect_valid_o(rv_d), .redirect_pc_o(rpc_d));

  // CSR file index: 0 mstatus, 1 mtvec, 2 mepc, 3 mcause, 4 unmapped
  function automatic int csr_idx(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h341: return 2;
      12'h342: return 3;
      default: return 4;
    endcase
  endfunction

  always_comb begin
    rdata_v = '0;
    rdata_d = '0;
    if (csr_idx(addr_v) < 4) rdata_v = mem_v[csr_idx(addr_v)];
    if (csr_idx(addr_d) < 4) rdata_d = mem_d[csr_idx(addr_d)];
  end

  always @(posedge clock) begin
    if (load_en) begin
      mem_v[0] <= load_ms; mem_v[1] <= load_tv; mem_v[2] <= load_ep; mem_v[3] <= '0;
      mem_d[0] <= load_ms; mem_d[1] <= load_tv; mem_d[2] <= load_ep; mem_d[3] <= '0;
    end else begin
      if (wen_v && csr_idx(addr_v) < 4) mem_v[csr_idx(addr_v)] <= wdata_v;
      if (wen_d && csr_idx(addr_d) < 4) mem_d[csr_idx(addr_d)] <= wdata_d;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference rules written as mask arithmetic on the architectural fields.
  function automatic logic [63:0] exp_trap_ms(input logic [63:0] ms);
    return (ms & ~64'h1888) | 64'h1800 | (ms[3] ? 64'h80 : 64'h0);
  endfunction

  function automatic logic [63:0] exp_mret_ms(input logic [63:0] ms);
    return (ms & ~64'h1888) | 64'h1880 | (ms[7] ? 64'h8 : 64'h0);
  endfunction

  function automatic logic [63:0] exp_target(input logic [63:0] tv, input logic [63:0] cause,
                                             input bit vec);
    logic [63:0] base;
    base = tv - (tv % 4);
    if (vec && (tv % 4 == 1) && cause[63])
      return base + (cause & 64'h7FFF_FFFF_FFFF_FFFF) * 4;
    return base;
  endfunction

  task automatic preload(input logic [63:0] ms, input logic [63:0] tv, input logic [63:0] ep);
    load_ms = ms; load_tv = tv; load_ep = ep; load_en = 1'b1;
    @(posedge clock); #1;
    load_en = 1'b0;
  endtask

  task automatic run_seq(input bit do_trap, input bit do_mret, input logic [63:0] pc,
                         input logic [63:0] cause, input logic [63:0] ms,
                         input logic [63:0] tv, input logic [63:0] ep, input int mret_k);
    logic [31:0] sm_v, sm_d, wm_v, wm_d, rm_v, rm_d, ex_s, ex_w, ex_r;
    logic [63:0] seen_v, seen_d, ex_pc_v, ex_pc_d, ex_ms, ex_ep, ex_mc;
    sm_v = 0; sm_d = 0; wm_v = 0; wm_d = 0; rm_v = 0; rm_d = 0; seen_v = 0; seen_d = 0;
    preload(ms, tv, ep);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      trap_req = (k == 0) && do_trap;
      mret_req = ((k == 0) && do_mret) || (k == mret_k);
      trap_pc = pc; trap_cause = cause;
      #1;
      sm_v[k] = stall_v; sm_d[k] = stall_d; wm_v[k] = wen_v; wm_d[k] = wen_d;
      rm_v[k] = rv_v; rm_d[k] = rv_d;
      if (rv_v) seen_v = rpc_v;
      if (rv_d) seen_d = rpc_d;
    end
    trap_req = 1'b0; mret_req = 1'b0;
    if (do_trap) begin
      ex_s = 32'h7F; ex_w = 32'h16; ex_r = 32'h40;
      ex_pc_v = exp_target(tv, cause, 1'b1); ex_pc_d = exp_target(tv, cause, 1'b0);
      ex_ms = exp_trap_ms(ms); ex_ep = pc; ex_mc = cause;
    end else begin
      ex_s = 32'h1F; ex_w = 32'h04; ex_r = 32'h10;
      ex_pc_v = ep & ~64'h3; ex_pc_d = ex_pc_v;
      ex_ms = exp_mret_ms(ms); ex_ep = ep; ex_mc = 0;
    end
    check_eq("stall_v", sm_v, ex_s);   check_eq("stall_d", sm_d, ex_s);
    check_eq("wen_v", wm_v, ex_w);     check_eq("wen_d", wm_d, ex_w);
    check_eq("redir_v", rm_v, ex_r);   check_eq("redir_d", rm_d, ex_r);
    check_eq("rpc_v", seen_v, ex_pc_v); check_eq("rpc_d", seen_d, ex_pc_d);
    check_eq("rpc_hold_v", rpc_v, ex_pc_v); check_eq("rpc_hold_d", rpc_d, ex_pc_d);
    check_eq("mstatus_v", mem_v[0], ex_ms); check_eq("mstatus_d", mem_d[0], ex_ms);
    check_eq("mepc_v", mem_v[2], ex_ep);    check_eq("mcause_v", mem_v[3], ex_mc);
    check_eq("mtvec_v", mem_v[1], tv);
  endtask

  task automatic reset_mid(input logic [63:0] pc, input logic [63:0] cause);
    logic [31:0] sm, wm, rm;
    sm = 0; wm = 0; rm = 0;
    preload(64'h8, 64'h8000_1001, 64'h0);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      trap_req = (k == 0); trap_pc = pc; trap_cause = cause;
      reset = (k == 3);
      #1;
      sm[k] = stall_v | stall_d; wm[k] = wen_v | wen_d; rm[k] = rv_v | rv_d;
    end
    check_eq("rst_stall", sm, 32'h0F);
    check_eq("rst_wen", wm, 32'h06);
    check_eq("rst_redir", rm, 32'h0);
    check_eq("rst_mstatus", mem_v[0], 64'h8);
    check_eq("rst_mepc", mem_v[2], pc);
    check_eq("rst_mcause", mem_d[3], cause);
    check_eq("rst_rpc", rpc_v | rpc_d, 64'h0);
  endtask

  task automatic back_to_back(input logic [63:0] ms, input logic [63:0] tv);
    logic [31:0] sm, wm, rm;
    int idle_wen;
    sm = 0; wm = 0; rm = 0; idle_wen = 0;
    preload(ms, tv, 64'h0);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      trap_req = (k <= 7); trap_pc = 64'h8000_0100; trap_cause = 64'd3;
      #1;
      sm[k] = stall_v; wm[k] = wen_v; rm[k] = rv_v;
      if (wen_v && !stall_v) idle_wen++;
    end
    trap_req = 1'b0;
    check_eq("b2b_stall", sm, 32'h3FFF);
    check_eq("b2b_wen", wm, 32'hB16);
    check_eq("b2b_redir", rm, 32'h2040);
    check_eq("b2b_idle_wen", idle_wen, 0);
    check_eq("b2b_mstatus", mem_v[0], exp_trap_ms(exp_trap_ms(ms)));
  endtask

  initial begin
    logic [63:0] r_pc, r_cause, r_ms, r_tv, r_ep;
    int mode;
    reset = 1'b1; trap_req = 1'b0; mret_req = 1'b0; trap_pc = '0; trap_cause = '0;
    load_en = 1'b0; load_ms = '0; load_tv = '0; load_ep = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset_addr", addr_v, 12'h0);
    check_eq("reset_wdata", wdata_v, 64'h0);
    check_eq("reset_wen", wen_v, 1'b0);
    check_eq("reset_stall", stall_v, 1'b0);
    check_eq("reset_redir", rv_v, 1'b0);
    check_eq("reset_rpc", rpc_v, 64'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_seq(1, 0, 64'h8000_0010, 64'd11, 64'h8, 64'h8000_1000, 64'h0, -1);
    check_eq("t1_mstatus_const", mem_v[0], 64'h1880);
    run_seq(0, 1, 64'h0, 64'h0, 64'h1880, 64'h0, 64'h8000_0014, -1);
    check_eq("t2_mstatus_const", mem_v[0], 64'h1888);
    run_seq(1, 0, 64'h8000_0020, 64'h8000_0000_0000_0007, 64'h0, 64'h8000_1001, 64'h0, -1);
    check_eq("t3_vec_const", rpc_v, 64'h8000_101C);
    run_seq(1, 0, 64'h8000_0020, 64'h7, 64'h0, 64'h8000_1001, 64'h0, -1);
    run_seq(1, 1, 64'h8000_0030, 64'd2, 64'h88, 64'h8000_2001, 64'h0, 2);
    reset_mid(64'h8000_0040, 64'h8000_0000_0000_0003);
    run_seq(1, 0, 64'h8000_0044, 64'h8000_0000_0000_000B, 64'h8, 64'h8000_1001, 64'h0, -1);
    back_to_back(64'h8, 64'h8000_3000);

    for (int i = 0; i < 40; i++) begin
      mode    = $urandom_range(0, 2);
      r_pc    = {$urandom, $urandom};
      r_cause = {$urandom_range(0, 1) == 1, 55'h0, 8'($urandom)};
      if ($urandom_range(0, 3) == 0) r_cause = {$urandom, $urandom};
      r_ms    = {$urandom, $urandom};
      r_tv    = {$urandom, $urandom};
      r_ep    = {$urandom, $urandom};
      run_seq(mode != 1, mode != 0, r_pc, r_cause, r_ms, r_tv, r_ep,
              (mode == 2) ? int'($urandom_range(1, 6)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
